// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX hazard operands, redirect and memory-stall inputs,
// and the stage enable / flush outputs. The master drives the pipeline side, the slave is the controller.
interface pipeline_hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] ex_rd;
  logic       ex_is_load;
  logic       br_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       pc_en;
  logic       ifid_en;
  logic       pipe_en;
  logic       flush_n;
  logic       hazflush_n;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_is_load,
           br_taken, mem_req, mem_ready,
    input  pc_en, ifid_en, pipe_en, flush_n, hazflush_n
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_is_load,
           br_taken, mem_req, mem_ready,
    output pc_en, ifid_en, pipe_en, flush_n, hazflush_n
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: memory freeze, branch redirect flush and load-use bubble insertion,
// with a saturating count of PC-stalled cycles. All stage controls are Mealy outputs.
module pipeline_hazard_ctrl #(
  parameter int unsigned FLUSH_CYC = 1,
  parameter int unsigned CNTW      = 16
) (
  input  logic                clk,
  input  logic                rst,
  pipeline_hazard_ctrl_if.slave hz,
  output logic [CNTW-1:0]     stall_count,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic            HAS_FLUSH = (FLUSH_CYC != 0);
  localparam logic [1:0]      CNT_INIT  = (FLUSH_CYC > 0) ? 2'(FLUSH_CYC - 1) : 2'd0;
  localparam logic [CNTW-1:0] CNT_MAX   = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE   = {{(CNTW-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [CNTW-1:0] stall_q;

  logic memstall;
  logic load_use;
  logic pc_en, ifid_en, pipe_en, flush_n, hazflush_n;

  assign memstall = hz.mem_req & ~hz.mem_ready;

  // x0 is hardwired to zero, so a load targeting it can never feed a consumer.
  assign load_use = hz.ex_is_load && (hz.ex_rd != 5'd0) &&
                    ((hz.id_rs1_used && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_rs2_used && (hz.id_rs2 == hz.ex_rd)));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    pipe_en    = 1'b1;
    flush_n    = 1'b1;
    hazflush_n = 1'b1;

    if (rst) begin
      state_d    = RUN;
      cnt_d      = 2'd0;
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      pipe_en    = 1'b0;
      flush_n    = 1'b0;
      hazflush_n = 1'b0;
    end else if (memstall) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      pipe_en = 1'b0;
      state_d = MEM_WAIT;
    end else begin
      unique case (state_q)
        // MEM_WAIT re-evaluates held events the cycle the memory completes.
        RUN, MEM_WAIT: begin
          state_d = RUN;
          if (hz.br_taken) begin
            flush_n = 1'b0;
            if (HAS_FLUSH) begin
              state_d = FLUSH;
              cnt_d   = CNT_INIT;
            end
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            hazflush_n = 1'b0;
          end
        end
        FLUSH: begin
          flush_n = 1'b0;
          if (cnt_q == 2'd0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pc_en && (stall_q != CNT_MAX)) begin
        stall_q <= stall_q + CNT_ONE;
      end
    end
  end

  assign hz.pc_en      = pc_en;
  assign hz.ifid_en    = ifid_en;
  assign hz.pipe_en    = pipe_en;
  assign hz.flush_n    = flush_n;
  assign hz.hazflush_n = hazflush_n;
  assign stall_count   = stall_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: each step pushes the expected controls and state to a
// scoreboard, then pops and checks them mid-cycle; stall_count is tracked by a small counter model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CNTW = 3;

  logic            clk;
  logic            rst;
  logic [CNTW-1:0] stall_count;
  logic [1:0]      state_o;

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(
    .FLUSH_CYC (1),
    .CNTW      (CNTW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hz          (bus.slave),
    .stall_count (stall_count),
    .state_o     (state_o)
  );

  typedef struct {
    string      tag;
    logic [4:0] outs;
    logic [1:0] st;
  } exp_t;

  exp_t            sb[$];
  int              n_pass  = 0;
  int              n_fail  = 0;
  int              n_total = 0;
  logic [CNTW-1:0] cnt_exp = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %b want %b", tag, got, want);
    end
  endtask

  // outs = {pc_en, ifid_en, pipe_en, flush_n, hazflush_n}
  task automatic step(input string tag, input logic [4:0] outs, input logic [1:0] st);
    exp_t e;
    logic [4:0] obs;
    e.tag  = tag;
    e.outs = outs;
    e.st   = st;
    sb.push_back(e);
    #2;
    e   = sb.pop_front();
    obs = {bus.pc_en, bus.ifid_en, bus.pipe_en, bus.flush_n, bus.hazflush_n};
    check({e.tag, "/ctl"},   {3'b0, obs},     {3'b0, e.outs});
    check({e.tag, "/state"}, {6'b0, state_o}, {6'b0, e.st});
    check({e.tag, "/cnt"},   {5'b0, stall_count}, {5'b0, cnt_exp});
    if (rst) cnt_exp = '0;
    else if (!e.outs[4] && cnt_exp != {CNTW{1'b1}}) cnt_exp = cnt_exp + 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0;
    bus.ex_rd = 5'd0; bus.ex_is_load = 1'b0; bus.br_taken = 1'b0;
    bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk);

    step("rst0", 5'b00000, 2'd0);
    step("rst1", 5'b00000, 2'd0);
    rst = 1'b0;
    step("idle", 5'b11111, 2'd0);

    // load-use on rs2
    bus.ex_is_load = 1'b1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.id_rs2_used = 1'b1;
    step("lu_rs2", 5'b00110, 2'd0);
    bus.ex_is_load = 1'b0;
    step("lu_rs2_after", 5'b11111, 2'd0);

    // x0 destination and unused operand never stall
    bus.ex_is_load = 1'b1; bus.ex_rd = 5'd0; bus.id_rs2 = 5'd0;
    step("lu_x0", 5'b11111, 2'd0);
    bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.id_rs2_used = 1'b0;
    step("lu_unused", 5'b11111, 2'd0);

    // load-use on rs1
    bus.id_rs1 = 5'd5; bus.id_rs1_used = 1'b1;
    step("lu_rs1", 5'b00110, 2'd0);
    bus.ex_is_load = 1'b0; bus.id_rs1_used = 1'b0;
    step("lu_rs1_after", 5'b11111, 2'd0);

    // taken branch: two flush cycles, pc_en stays high
    bus.br_taken = 1'b1;
    step("br", 5'b11101, 2'd0);
    bus.br_taken = 1'b0;
    step("br_flush", 5'b11101, 2'd1);
    step("br_done", 5'b11111, 2'd0);

    // memory freeze masking a load-use hazard, bubble on completion
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    bus.ex_is_load = 1'b1; bus.ex_rd = 5'd7; bus.id_rs1 = 5'd7; bus.id_rs1_used = 1'b1;
    step("mw0", 5'b00011, 2'd0);
    step("mw1", 5'b00011, 2'd2);
    step("mw2", 5'b00011, 2'd2);
    bus.mem_ready = 1'b1;
    step("mw_haz", 5'b00110, 2'd2);
    bus.mem_req = 1'b0; bus.mem_ready = 1'b0; bus.ex_is_load = 1'b0; bus.id_rs1_used = 1'b0;
    step("mw_done", 5'b11111, 2'd0);

    // branch held under a memory stall, then reset in the flush cycle
    bus.br_taken = 1'b1; bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    step("bm0", 5'b00011, 2'd0);
    step("bm1", 5'b00011, 2'd2);
    bus.mem_ready = 1'b1;
    step("bm_br", 5'b11101, 2'd2);
    bus.br_taken = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
    rst = 1'b1;
    step("bm_rst", 5'b00000, 2'd1);
    rst = 1'b0;
    step("bm_after", 5'b11111, 2'd0);

    // branch seen during FLUSH is ignored
    bus.br_taken = 1'b1;
    step("br2", 5'b11101, 2'd0);
    step("br2_ign", 5'b11101, 2'd1);
    bus.br_taken = 1'b0;
    step("br2_done", 5'b11111, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
